gpio_sequencer: RTL
===================

Name: gpio_sequencer

Overview:
- Timed pattern generator that drives the GPIO output stream. Software or a DMA pushes {hold, value} command words over AXI-Stream into an internal FIFO.
- On a start pulse the block plays the queued words back on a 16-bit output stream. Each value is held for a programmed number of cycles.
- The output stream feeds the GPIO buffer's s_axis input. Between sequences the output sits at a fixed idle value.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of 2, minimum 2
- IDLE_VALUE, 16'h0000, value driven on m_axis_tdata when not running

Ports:
- aclk  in  1  clock, 250 MHz domain
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  32  command: [15:0] GPIO value, [31:16] hold count
- s_axis_tvalid  in  1  command valid
- s_axis_tready  out  1  command accepted when high with tvalid
- start  in  1  single-cycle pulse; begins playback
- abort  in  1  single-cycle pulse; stops playback and flushes FIFO
- m_axis_tdata  out  16  current GPIO output level
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready; low stalls the hold counter
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at normal sequence completion
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Clock and reset: one clock (aclk); reset is synchronous and active-low (aresetn).
- Reset values:
  - State IDLE, FIFO empty, fifo_count=0.
  - m_axis_tdata=IDLE_VALUE, m_axis_tvalid=0, busy=0, done=0.
  - Hold counter=0.
  - s_axis_tready=0 while aresetn low.
- m_axis_tvalid: registered. 1 from the first cycle after reset deasserts, stays 1 until the next reset. m_axis_tdata is a level, always valid.
- FIFO:
  - Push when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !full; combinational from registered count only, no pass-through when full.
  - Push and pop in the same cycle are both allowed: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, RUN.
- IDLE:
  - Entered only when start && !abort && !empty. Then pop the head entry, register m_axis_tdata=value, counter=hold; next state RUN.
  - The first value appears on m_axis_tdata in the cycle after start is sampled (latency 1).
  - start with an empty FIFO is ignored; stays in IDLE, no done pulse.
- RUN, each cycle with m_axis_tready=1:
  - counter!=0: decrement.
  - counter==0 and FIFO not empty: pop the next entry, load value and hold in the same cycle (zero-bubble).
  - counter==0 and FIFO empty: go to IDLE, m_axis_tdata=IDLE_VALUE, done=1 for one cycle.
- RUN with m_axis_tready=0: counter and state frozen, m_axis_tdata held.
- Entry timing: an entry with hold h occupies exactly h+1 cycles of m_axis_tready-high time. hold=0 gives 1 cycle. hold=16'hFFFF gives 65536 cycles.
- start while in RUN: ignored.
- abort, any state:
  - Next cycle: state IDLE, m_axis_tdata=IDLE_VALUE, FIFO flushed (count=0), counter=0, no done pulse.
  - A push in the same cycle as abort is discarded.
  - abort wins over a simultaneous start.
- Pushes during RUN are legal and extend the running sequence if they arrive before the FIFO runs dry.
- busy equals (state==RUN), registered.
- Reset asserted mid-RUN: all state returns to reset values in the next cycle. Queued entries are lost.

Test Plan:
- Reset, then push {hold=2,0x00A5}, {0,0x5A00}, {1,0xFFFF}, then pulse start.
  - Required m_axis_tdata from start+1: A5,A5,A5,5A00,FFFF,FFFF, then IDLE_VALUE.
  - done pulses on the cycle tdata returns to idle; busy high for exactly 6 cycles.
- Push FIFO_DEPTH+2 words with tvalid held high.
  - s_axis_tready drops after 16 accepts; fifo_count=16.
  - Start, then confirm the remaining two words are accepted as the FIFO drains; all 18 values play in order with no gaps.
- Run {hold=5,0x1234}; deassert m_axis_tready for 3 cycles mid-hold.
  - 0x1234 is visible for 9 cycles total; done timing shifts by 3.
- Queue 4 entries, start, assert abort at cycle 3.
  - Next cycle: m_axis_tdata=IDLE_VALUE, fifo_count=0, busy=0, no done pulse.
  - A following start is ignored.
- Start with an empty FIFO: no state change, no done pulse.
  - Start and abort in the same cycle with 2 entries queued: FIFO flushed, stays IDLE.
- Assert aresetn=0 mid-RUN for 1 cycle.
  - All outputs return to reset values, including m_axis_tvalid=0 during reset.
  - After release, a new push/start sequence plays correctly.

Source files
------------

// File: rtl/gpio_sequencer_if.sv
// Command and playback stream bundle for gpio_sequencer, plus its control and status lines.
interface gpio_sequencer_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          start;
    logic          abort;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
    logic          done;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, start, abort, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, busy, done, fifo_count
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, start, abort, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, busy, done, fifo_count
    );
endinterface

// File: rtl/gpio_sequencer.sv
// Timed GPIO pattern player: queued {hold, value} words are replayed on a 16-bit stream,
// each value held for hold+1 downstream-ready cycles.
//
// state | meaning
// IDLE  | output parked at IDLE_VALUE, waiting for start with a non-empty FIFO
// RUN   | playing queued entries; hold counter advances only while m_axis_tready is high
module gpio_sequencer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
    input logic            aclk,
    input logic            aresetn,
    gpio_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   tdata_q, tdata_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          tvalid_q;
    logic          full, empty, tready, push, pop, flush;
    logic [31:0]   head;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign tready = aresetn && !full;
    assign push   = bus.s_axis_tvalid && tready && !bus.abort;

    assign bus.s_axis_tready = tready;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.fifo_count    = count_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tdata_d = tdata_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            hold_d  = '0;
            tdata_d = IDLE_VALUE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !empty) begin
                        pop     = 1'b1;
                        tdata_d = head[15:0];
                        hold_d  = head[31:16];
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.m_axis_tready) begin
                        if (hold_q != '0) begin
                            hold_d = hold_q - 16'd1;
                        end else if (!empty) begin
                            pop     = 1'b1;
                            tdata_d = head[15:0];
                            hold_d  = head[31:16];
                        end else begin
                            state_d = IDLE;
                            tdata_d = IDLE_VALUE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            tdata_q  <= IDLE_VALUE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            tdata_q  <= tdata_d;
            done_q   <= done_d;
            busy_q   <= (state_d == RUN);
            tvalid_q <= 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= bus.s_axis_tdata;
    end
endmodule
